// File: rtl/kw_fifo_rd_stream.sv
`timescale 1ns/1ps
// kw_fifo_rd_stream
// Read-side adapter for the FF-based FIFO. Issues pops against a credit of
// free skid-buffer slots, absorbs the FIFO's one-cycle registered read
// latency, and presents the buffered words as a valid/ready stream.
//
// Ports
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   flush            synchronous discard of buffered and in-flight words
//   fifo_pop_req     pop request to the FIFO (combinational)
//   fifo_empty       FIFO empty flag
//   fifo_data        FIFO read data, valid the cycle after an accepted pop
//   fifo_error       FIFO error flag
//   out_valid        stream word available
//   out_ready        consumer accepts the word
//   out_data         oldest buffered word
//   buf_level        entries currently held (0..BUF_DEPTH)
//   err              sticky error, cleared only by reset
module kw_fifo_rd_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned LVL_WIDTH  = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    output logic                  fifo_pop_req,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_error,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [LVL_WIDTH-1:0]  buf_level,
    output logic                  err
);

    localparam int unsigned PTR_WIDTH = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned SUM_WIDTH = LVL_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(BUF_DEPTH - 1);
    localparam logic [SUM_WIDTH-1:0] DEPTH_SUM = SUM_WIDTH'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] entries [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;
    logic [LVL_WIDTH-1:0]  occ;
    logic                  valid_q;
    logic                  inflight;
    logic                  err_q;

    logic [PTR_WIDTH-1:0]  head_next;
    logic [PTR_WIDTH-1:0]  tail_next;
    logic [LVL_WIDTH-1:0]  occ_next;
    logic                  fire;
    logic                  capture;
    logic                  pop_out;
    logic [SUM_WIDTH-1:0]  credit;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign fire    = valid_q && out_ready;
    assign capture = inflight && !flush;
    assign pop_out = fire && !flush;

    // Slots already claimed after this edge; one extra bit keeps the sum from wrapping.
    // fire implies occ >= 1, so the subtraction never underflows.
    assign credit = SUM_WIDTH'(occ) + SUM_WIDTH'(inflight) - SUM_WIDTH'(fire);

    // out_ready reaches the pop request combinationally so a full-rate stream sustains.
    assign fifo_pop_req = reset_n && !flush && !fifo_empty && (credit < DEPTH_SUM);

    // Next pointer/occupancy; a capture into a full buffer is excluded by the credit.
    always_comb begin
        head_next = head;
        tail_next = tail;
        occ_next  = occ;
        if (flush) begin
            head_next = '0;
            tail_next = '0;
            occ_next  = '0;
        end else begin
            if (pop_out) begin
                head_next = ptr_inc(head);
            end
            if (capture) begin
                tail_next = ptr_inc(tail);
            end
            occ_next = occ + LVL_WIDTH'(capture) - LVL_WIDTH'(pop_out);
        end
    end

    // Control state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            valid_q  <= 1'b0;
            inflight <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            head     <= head_next;
            tail     <= tail_next;
            occ      <= occ_next;
            valid_q  <= (occ_next != '0);
            inflight <= fifo_pop_req && !flush;
            err_q    <= err_q || fifo_error;
        end
    end

    // Skid buffer storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (capture) begin
            entries[tail] <= fifo_data;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = entries[head];
    assign buf_level = occ;
    assign err       = err_q;

endmodule

// File: tb/tb_kw_fifo_rd_stream.sv
`timescale 1ns/1ps
module tb_kw_fifo_rd_stream;

    localparam int unsigned DW = 16;
    localparam int unsigned BD = 2;
    localparam int unsigned LW = $clog2(BD + 1);

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          fifo_pop_req;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_error;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [LW-1:0] buf_level;
    logic          err;

    int checks = 0;
    int errors = 0;
    int fires  = 0;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_w;
    logic [DW-1:0] mon_w;

    logic          lat_pop  [7];
    logic          lat_vld  [7];
    logic [DW-1:0] lat_data [7];

    kw_fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .fifo_pop_req (fifo_pop_req),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_error   (fifo_error),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .buf_level    (buf_level),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty <= 1'b0;
    endtask

    // FIFO model with one-cycle registered read; popped words become scoreboard expectations.
    always @(posedge clock) begin
        if (reset_n && fifo_pop_req) begin
            checks++;
            if (fifo_empty || fq.size() == 0) begin
                errors++;
                $display("FAIL pop_while_empty: pop_req=1 with fifo_empty=%0b", fifo_empty);
            end else begin
                model_w = fq.pop_front();
                fifo_data <= model_w;
                exp_q.push_back(model_w);
                fifo_empty <= (fq.size() == 0);
            end
        end
    end

    // Scoreboard monitor: a handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                fires++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_unexpected: got 0x%0h with nothing expected", out_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (out_data !== mon_w) begin
                        errors++;
                        $display("FAIL stream_data: got 0x%0h expected 0x%0h", out_data, mon_w);
                    end
                end
            end
            if (flush) begin
                exp_q.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int f0;
        int pushed;
        int cyc;
        bit done;

        lat_pop  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        lat_vld  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        lat_data = '{16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000};

        reset_n    = 1'b0;
        flush      = 1'b0;
        fifo_error = 1'b0;
        out_ready  = 1'b0;
        fifo_empty <= 1'b1;
        fifo_data  <= '0;

        // Reset values, with the FIFO already non-empty.
        repeat (2) @(posedge clock);
        for (int i = 1; i <= 4; i++) push(DW'(i));
        sample();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data), 32'd0);
        chk("rst_buf_level", 32'(buf_level), 32'd0);
        chk("rst_pop_req",   32'(fifo_pop_req), 32'd0);
        chk("rst_err",       32'(err), 32'd0);

        // Latency: release reset, cycle 0 is the first with reset_n=1.
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c != 0) tick();
            sample();
            chk($sformatf("lat_pop_c%0d", c), 32'(fifo_pop_req), 32'(lat_pop[c]));
            chk($sformatf("lat_valid_c%0d", c), 32'(out_valid), 32'(lat_vld[c]));
            if (lat_vld[c]) chk($sformatf("lat_data_c%0d", c), 32'(out_data), 32'(lat_data[c]));
        end

        // Backpressure: only BUF_DEPTH pops, head word held stable.
        tick();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(DW'(i));
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (fifo_pop_req) pops++;
            if (k >= 3) begin
                chk($sformatf("bp_hold_valid_k%0d", k), 32'(out_valid), 32'd1);
                chk($sformatf("bp_hold_data_k%0d", k), 32'(out_data), 32'h0001);
            end
            tick();
        end
        sample();
        chk("bp_pops", 32'(pops), 32'(BD));
        chk("bp_level", 32'(buf_level), 32'd2);
        chk("bp_data", 32'(out_data), 32'h0001);
        tick();
        out_ready = 1'b1;
        f0 = fires;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk($sformatf("bp_drain_valid_k%0d", k), 32'(out_valid), 32'd1);
            tick();
        end
        sample();
        chk("bp_drain_done", 32'(out_valid), 32'd0);
        chk("bp_drain_fires", 32'(fires - f0), 32'd8);

        // Flush with one buffered and one in-flight word, then flush with a handshake.
        tick();
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) push(DW'(16'h00A0 + i));
        sample(); tick();                  // c0
        sample(); tick();                  // c1
        flush = 1'b1;                      // c2
        sample();
        chk("fl1_pre_level", 32'(buf_level), 32'd1);
        tick();
        flush = 1'b0;                      // c3
        sample();
        chk("fl1_post_level", 32'(buf_level), 32'd0);
        chk("fl1_post_valid", 32'(out_valid), 32'd0);
        tick();                            // c4
        tick();                            // c5
        sample();
        chk("fl1_next_valid", 32'(out_valid), 32'd1);
        chk("fl1_next_data", 32'(out_data), 32'h00A3);
        tick();                            // c6
        out_ready = 1'b1;
        flush     = 1'b1;
        sample();
        chk("fl2_pre_level", 32'(buf_level), 32'd2);
        chk("fl2_pop_blocked", 32'(fifo_pop_req), 32'd0);
        tick();                            // c7
        flush = 1'b0;
        sample();
        chk("fl2_post_level", 32'(buf_level), 32'd0);
        chk("fl2_post_valid", 32'(out_valid), 32'd0);
        tick();                            // c8
        tick();                            // c9
        sample();
        chk("fl2_next_data", 32'(out_data), 32'h00A5);
        tick();                            // c10
        sample();
        chk("fl2_last_data", 32'(out_data), 32'h00A6);
        tick();                            // c11
        sample();
        chk("fl2_done", 32'(out_valid), 32'd0);

        // Random ready with a trickle-fed FIFO.
        f0     = fires;
        pushed = 0;
        done   = 1'b0;
        cyc    = 0;
        while (!done && cyc < 3000) begin
            tick();
            out_ready = 1'($urandom_range(0, 1));
            if (pushed < 200 && $urandom_range(0, 1) == 1) begin
                push(DW'(pushed * 16'h0137 + 16'h0005));
                pushed++;
            end
            done = (pushed == 200) && (fq.size() == 0) && (exp_q.size() == 0);
            cyc++;
        end
        chk("rnd_timeout", 32'(done), 32'd1);
        chk("rnd_fires", 32'(fires - f0), 32'd200);

        // Sticky error.
        out_ready = 1'b1;
        tick();
        sample();
        chk("err_before", 32'(err), 32'd0);
        tick();
        fifo_error = 1'b1;
        tick();
        fifo_error = 1'b0;
        sample();
        chk("err_set", 32'(err), 32'd1);
        repeat (5) tick();
        sample();
        chk("err_held", 32'(err), 32'd1);

        // Reset mid-stream: outputs clear immediately.
        tick();
        for (int i = 1; i <= 6; i++) push(DW'(16'h00B0 + i));
        repeat (3) tick();
        sample();
        chk("ms_active", 32'(out_valid), 32'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ms_out_valid", 32'(out_valid), 32'd0);
        chk("ms_out_data",  32'(out_data), 32'd0);
        chk("ms_buf_level", 32'(buf_level), 32'd0);
        chk("ms_err",       32'(err), 32'd0);
        chk("ms_pop_req",   32'(fifo_pop_req), 32'd0);
        fq.delete();
        exp_q.delete();
        fifo_empty <= 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        push(16'h00C1);
        push(16'h00C2);
        repeat (8) tick();
        sample();
        chk("end_drained", 32'(exp_q.size()), 32'd0);
        chk("end_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
